rr_arbiter8: RTL and testbench

- Round-robin arbiter sharing one resource among 8 requesters; the round-robin generalisation of the team's 8-to-3 lowest-index priority encoder.
- Sits in front of a shared datapath port. Produces a one-hot grant plus its 3-bit encoded index.
- Holds the grant while the winner keeps requesting, then rotates priority past the last winner.

---
 rtl/rr_arbiter8.sv | 144 ++++++++++++++
 tb/tb_rr_arbiter8.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter for 8 requesters sharing one datapath port.
// Grants are registered, one-hot, and held while the owner keeps requesting.
// After each release the priority pointer moves one past the last owner.
// One idle bubble cycle always follows a release before the next arbitration.
// Optional build macro ARB_TIMEOUT_EN: forces a release after MAX_HOLD
// consecutive grant cycles so that one requester cannot hold the port forever.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] REQ,
  output logic [7:0] GNT,
  output logic [2:0] GNT_ID,
  output logic       BUSY
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [2:0]         id_q, id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         gnt_q, gnt_d;
  logic               busy_q, busy_d;

  logic               win_found;
  logic [2:0]         win_id;
  logic [2:0]         cand;
  logic               timeout_hit;
  logic               owner_release;

  // Reject parameter sets the hold counter cannot represent.
  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (MAX_HOLD >> CNT_W) != 0) begin : g_param_check
    $error("rr_arbiter8: MAX_HOLD must be 2..255 and below 2**CNT_W");
  end

  // Scan requesters starting at the pointer, wrapping at 7 -> 0.
  always_comb begin
    // NOTE: every variable driven here gets a default first, otherwise
    // paths that skip an assignment would infer a latch.
    win_found = 1'b0;
    win_id    = ptr_q;
    cand      = ptr_q;
    for (int i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!win_found && REQ[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  // The owner has already used MAX_HOLD-1 cycles; this edge ends the tenure.
  assign timeout_hit = (cnt_q == CNT_W'(MAX_HOLD - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // The owner gives up the port either by dropping its request or by timeout.
  assign owner_release = (state_q == GRANT) && (!REQ[id_q] || timeout_hit);

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  // Next-state logic: arbitrate from IDLE, fall back to IDLE on any release.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (win_found)     state_d = GRANT;
      GRANT:   if (owner_release) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Output and datapath next values for grant, owner, pointer and hold count.
  always_comb begin
    gnt_d  = gnt_q;
    busy_d = busy_q;
    id_d   = id_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d  = 8'b1 << win_id;
          busy_d = 1'b1;
          id_d   = win_id;
          cnt_d  = '0;
        end else begin
          gnt_d  = 8'h00;
          busy_d = 1'b0;
        end
      end
      GRANT: begin
        if (owner_release) begin
          // Owner keeps its ID visible; it becomes lowest priority next round.
          gnt_d  = 8'h00;
          busy_d = 1'b0;
          ptr_d  = id_q + 3'd1;
          cnt_d  = '0;
        end else if (cnt_q != '1) begin
          cnt_d  = cnt_q + 1'b1;
        end
      end
      default: begin
        gnt_d  = 8'h00;
        busy_d = 1'b0;
      end
    endcase
  end

  // Registered outputs and arbitration bookkeeping.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gnt_q  <= 8'h00;
      busy_q <= 1'b0;
      id_q   <= 3'd0;
      ptr_q  <= 3'd0;
      cnt_q  <= '0;
    end else begin
      gnt_q  <= gnt_d;
      busy_q <= busy_d;
      id_q   <= id_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign GNT    = gnt_q;
  assign GNT_ID = id_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed and random stimulus for rr_arbiter8, checked against
// a behavioural round-robin model; honours ARB_TIMEOUT_EN with MAX_HOLD=4.
module tb_rr_arbiter8;

  localparam int MH = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] REQ = 8'h00;
  logic [7:0] GNT;
  logic [2:0] GNT_ID;
  logic       BUSY;

  int total = 0;
  int bad   = 0;

  // Reference model state: owner, priority start, tenure length.
  bit m_busy;
  int m_id;
  int m_ptr;
  int m_cnt;

  rr_arbiter8 #(.MAX_HOLD(MH), .CNT_W(8)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .REQ    (REQ),
    .GNT    (GNT),
    .GNT_ID (GNT_ID),
    .BUSY   (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_id   = 0;
    m_ptr  = 0;
    m_cnt  = 0;
  endtask

  // One clock of the arbitration rules applied to the sampled request vector.
  task automatic model_next(input logic [7:0] r);
    bit found;
    bit hit;
    if (!m_busy) begin
      if (r != 8'h00) begin
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
          if (!found && r[(m_ptr + k) % 8]) begin
            found = 1'b1;
            m_id  = (m_ptr + k) % 8;
          end
        end
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else begin
      hit = 1'b0;
`ifdef ARB_TIMEOUT_EN
      hit = (m_cnt == MH - 1);
`endif
      if (!r[m_id] || hit) begin
        m_busy = 1'b0;
        m_ptr  = (m_id + 1) % 8;
        m_cnt  = 0;
      end else if (m_cnt < 255) begin
        m_cnt++;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [7:0] exp_gnt;
    exp_gnt = m_busy ? (8'h01 << m_id) : 8'h00;
    check({tag, "_gnt"}, GNT, exp_gnt);
    check({tag, "_id"}, {5'b0, GNT_ID}, 8'(m_id));
    check({tag, "_busy"}, {7'b0, BUSY}, {7'b0, m_busy});
  endtask

  // Drive REQ, advance one edge, compare against the model #1 after the edge.
  task automatic step(input logic [7:0] r, input string tag);
    REQ = r;
    model_next(r);
    @(posedge CLK);
    #1;
    check_model(tag);
  endtask

  // Assert reset between edges; outputs must clear without waiting for a clock.
  task automatic apply_reset(input string tag);
    #2;
    RST = 1'b1;
    #1;
    check({tag, "_async_gnt"}, GNT, 8'h00);
    check({tag, "_async_busy"}, {7'b0, BUSY}, 8'h00);
    check({tag, "_async_id"}, {5'b0, GNT_ID}, 8'h00);
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    logic [7:0] r;
    model_reset();

    // Power-on reset, then idle with no requests.
    #1;
    check("por_gnt", GNT, 8'h00);
    check("por_busy", {7'b0, BUSY}, 8'h00);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int i = 0; i < 5; i++) step(8'h00, "idle");

    // Single requester 4 for four cycles, then released.
    step(8'h10, "single");
    check("single_first_gnt", GNT, 8'h10);
    for (int i = 0; i < 3; i++) step(8'h10, "single_hold");
    step(8'h00, "single_rel");
    step(8'hFF, "single_ptr");
    check("single_ptr5", {5'b0, GNT_ID}, 8'd5);
    step(8'h00, "single_rel2");

    // Reset in the middle of a tenure returns the pointer to 0.
    step(8'h40, "mid");
    apply_reset("mid_rst");
    step(8'hFF, "after_rst");
    check("after_rst_win0", {5'b0, GNT_ID}, 8'd0);

    // Rotation: all requesting, each owner releases after two grant cycles.
    apply_reset("rot_rst");
    for (int t = 0; t < 9; t++) begin
      step(8'hFF, "rot_grant");
      check("rot_order", {5'b0, GNT_ID}, 8'(t % 8));
      step(8'hFF, "rot_hold");
      r = 8'hFF & ~(8'h01 << (t % 8));
      step(r, "rot_rel");
      check("rot_bubble", GNT, 8'h00);
    end

    // Wrap: pointer at 6 picks 7 over 0, then 7's release wraps pointer to 0.
    apply_reset("wrap_rst");
    step(8'h20, "wrap_g5");
    step(8'h00, "wrap_r5");
    step(8'h81, "wrap_g7");
    check("wrap_win7", {5'b0, GNT_ID}, 8'd7);
    step(8'h01, "wrap_r7");
    step(8'h81, "wrap_g0");
    check("wrap_win0", {5'b0, GNT_ID}, 8'd0);

    // Simultaneous release of 3 with new requests on 2 and 5.
    apply_reset("sim_rst");
    step(8'h08, "sim_g3");
    step(8'h24, "sim_rel");
    check("sim_bubble", {7'b0, BUSY}, 8'h00);
    step(8'h24, "sim_arb");
    check("sim_win5", {5'b0, GNT_ID}, 8'd5);

    // Continuous requests from 0 and 1 (exercises the timeout when enabled).
    apply_reset("hold_rst");
    for (int i = 0; i < 14; i++) step(8'h03, "hold");

    // Random traffic: owner usually keeps requesting, occasional reset.
    apply_reset("rnd_rst");
    for (int i = 0; i < 400; i++) begin
      r = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) r = r & 8'($urandom_range(0, 255));
      if (m_busy) begin
        if ($urandom_range(0, 9) < 8) r[m_id] = 1'b1;
        else                          r[m_id] = 1'b0;
      end
      if ($urandom_range(0, 59) == 0) apply_reset("rnd_mid_rst");
      else                            step(r, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
